// File: rtl/if_stage.sv
// Instruction-fetch stage: issues one imem read at a time and presents the
// returned instruction to decode, with execute-stage redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_take_br,
  input  logic [31:0] EX_br_pc,
  input  logic        IF_ID_rdy,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_pc,
  output logic [31:0] IF_inst,
  output logic        IF_vld
);

  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic        slot_free;

  assign slot_free = !IF_vld || IF_ID_rdy;
  assign imem_req  = rst && (state == FETCH) && slot_free && !EX_take_br;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      IF_vld   <= 1'b0;
      IF_pc    <= 32'h0000_0000;
      IF_inst  <= NOP_INST;
    end else if (EX_take_br) begin
      // Redirect wins over consume and response; a still-pending read must be drained in DROP.
      fetch_pc <= EX_br_pc & 32'hFFFF_FFFC;
      IF_vld   <= 1'b0;
      IF_inst  <= NOP_INST;
      case (state)
        WAIT, DROP: state <= imem_rvalid ? FETCH : DROP;
        default:    state <= FETCH;
      endcase
    end else begin
      if (IF_vld && IF_ID_rdy) begin
        IF_vld  <= 1'b0;
        IF_inst <= NOP_INST;
      end
      case (state)
        FETCH: begin
          if (imem_req) begin
            req_pc <= fetch_pc;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            IF_inst  <= imem_rdata;
            IF_pc    <= req_pc;
            IF_vld   <= 1'b1;
            fetch_pc <= req_pc + 32'd4;
            state    <= FETCH;
          end
        end
        DROP: begin
          if (imem_rvalid) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013: IF_inst value while IF_vld is low.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-low, sampled on the rising edge of clk.
REQ-005 EX_take_br  input  1  redirect request from the execute stage; already gated by execute-valid.
REQ-006 EX_br_pc  input  32  redirect target, sampled when EX_take_br=1.
REQ-007 IF_ID_rdy  input  1  decode accepts IF_pc/IF_inst this cycle.
REQ-008 imem_req  output  1  instruction-memory read request; one-cycle pulse per request.
REQ-009 imem_addr  output  32  read address; meaningful only when imem_req=1.
REQ-010 imem_rvalid  input  1  read response valid; arrives one or more cycles after imem_req.
REQ-011 imem_rdata  input  32  read data; valid only when imem_rvalid=1.
REQ-012 IF_pc  output  32  PC of the presented instruction.
REQ-013 IF_inst  output  32  presented instruction.
REQ-014 IF_vld  output  1  IF_pc/IF_inst valid; consumed when IF_vld=1 and IF_ID_rdy=1.

Function
REQ-015 The block SHALL keep at most one imem request outstanding at any time.
REQ-016 State machine SHALL have exactly the states FETCH, WAIT and DROP.
REQ-017 Slot free means: IF_vld=0, or IF_vld=1 and IF_ID_rdy=1 in the same cycle.
REQ-018 FETCH behaviour:
- imem_req = slot free AND NOT EX_take_br; imem_addr = fetch PC.
- On issue, the block SHALL latch req_pc = fetch PC and go to WAIT.
- Otherwise it stays in FETCH.
REQ-019 WAIT with imem_rvalid=1 and EX_take_br=0:
- IF_inst <= imem_rdata, IF_pc <= req_pc, IF_vld <= 1.
- Fetch PC <= req_pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- Next state FETCH.
- Minimum fetch-to-present latency with 1-cycle memory: 2 cycles.
REQ-020 WAIT with imem_rvalid=0 and EX_take_br=0 SHALL hold all state.
REQ-021 A consume (IF_vld=1 and IF_ID_rdy=1) with no new data loaded in that cycle SHALL clear IF_vld on the next edge.
REQ-022 While IF_vld=1 and IF_ID_rdy=0, IF_pc, IF_inst and IF_vld SHALL hold stable.
REQ-023 EX_take_br=1, in any state, SHALL on that edge:
- set fetch PC <= {EX_br_pc[31:2], 2'b00};
- clear IF_vld;
- suppress imem_req in that cycle.
REQ-024 Redirect next-state rules:
- from FETCH -> FETCH;
- from WAIT with imem_rvalid=0 -> DROP;
- from WAIT with imem_rvalid=1 -> FETCH, with the returned data discarded;
- from DROP with imem_rvalid=0 -> DROP (new target kept);
- from DROP with imem_rvalid=1 -> FETCH.
REQ-025 DROP with EX_take_br=0 SHALL discard the response when imem_rvalid=1 and then go to FETCH, without touching the IF outputs.
REQ-026 In DROP, imem_req SHALL stay 0.
REQ-027 imem_rvalid in state FETCH SHALL be ignored.
REQ-028 When a redirect and a consume occur in the same cycle, the redirect SHALL take priority: IF_vld = 0 next cycle.
REQ-029 While IF_vld=0, IF_inst SHALL equal NOP_INST.

Reset
REQ-030 With rst=0 at a clock edge, the block SHALL set: state=FETCH, fetch PC=RESET_PC, req_pc=RESET_PC, IF_vld=0, IF_pc=0, IF_inst=NOP_INST.
REQ-031 imem_req SHALL be 0 in every cycle where rst=0.
REQ-032 Reset asserted mid-request SHALL abandon the outstanding request; the instruction memory shares rst, so no stale response follows.

Verification
REQ-033 Reset release: RESET_PC=0x100, rst=0 for 2 cycles -> imem_req=0 and IF_vld=0 during reset; first cycle after release imem_req=1, imem_addr=0x100.
REQ-034 Streaming fetch: 1-cycle memory, IF_ID_rdy=1 -> requests at 0x100, 0x104, 0x108 on alternate cycles; IF_pc/IF_inst match each address/data pair.
REQ-035 Back-pressure: IF_vld=1, IF_ID_rdy=0 for 5 cycles -> outputs stable, imem_req=0; on IF_ID_rdy=1 -> imem_req=1 same cycle at next PC.
REQ-036 Redirect in WAIT: EX_take_br=1 with EX_br_pc=0x200, response 0xDEAD_BEEF arrives 3 cycles later -> response discarded, IF_vld stays 0, next imem_addr=0x200.
REQ-037 Redirect collisions:
- EX_take_br coincident with imem_rvalid=1 and with a consume -> IF_vld=0 next cycle, data dropped, state FETCH.
- Second EX_take_br in DROP (0x300) -> fetch resumes at 0x300.
REQ-038 Wrap and alignment: EX_br_pc=0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000; EX_br_pc=0x0000_0203 -> imem_addr=0x0000_0200.
